forward_hazard_ctrl: RTL and testbench

Pipeline control block that produces the EXE-stage forwarding selects and the pipeline stall. It is the producer side of the EXE stage's operand/store-value multiplexers. It tracks destination tags of in-flight instructions through EXE, MEM and WB with internal tag registers. It compares them against the source registers of the instruction in ID and the instruction in EXE, then emits `val1_sel`, `val2_sel` and `ST_val_sel`, plus a load-use / no-forwarding stall that freezes IF/ID and injects a bubble into EXE.

---
 rtl/forward_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// forward_hazard_ctrl
//
// Control block for the EXE-stage forwarding multiplexers and the pipeline
// stall. It keeps a destination tag for each in-flight instruction in EXE,
// MEM and WB. It compares those tags with the sources of the instruction in
// EXE to produce the operand / store-value selects. It compares them with the
// sources of the instruction in ID to produce the load-use / no-forwarding
// stall.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   forward_en                    : 1 = forward, 0 = resolve RAW hazards by stalling
//   flush                         : instruction in ID is wrong-path (branch taken)
//   id_valid                      : ID holds a real instruction
//   id_src1/id_src2/id_st_src     : ID source / second source / store-data register
//   id_src2_used, id_st_used      : id_src2 / id_st_src are actually read
//   id_dest, id_wb_en, id_mem_read: ID destination, writes back, is a load
//   val1_sel/val2_sel/ST_val_sel  : 0 = own operand, 1 = MEM ALU result, 2 = WB result
//   stall                         : hold PC and IF/ID, bubble into EXE
// -----------------------------------------------------------------------------
module forward_hazard_ctrl #(
   parameter int REG_ADDR_LEN = 5,
   parameter int FORW_SEL_LEN = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    forward_en,
   input  logic                    flush,
   input  logic                    id_valid,
   input  logic [REG_ADDR_LEN-1:0] id_src1,
   input  logic [REG_ADDR_LEN-1:0] id_src2,
   input  logic [REG_ADDR_LEN-1:0] id_st_src,
   input  logic                    id_src2_used,
   input  logic                    id_st_used,
   input  logic [REG_ADDR_LEN-1:0] id_dest,
   input  logic                    id_wb_en,
   input  logic                    id_mem_read,
   output logic [FORW_SEL_LEN-1:0] val1_sel,
   output logic [FORW_SEL_LEN-1:0] val2_sel,
   output logic [FORW_SEL_LEN-1:0] ST_val_sel,
   output logic                    stall
);

   localparam logic [FORW_SEL_LEN-1:0] SEL_OWN = FORW_SEL_LEN'(0);
   localparam logic [FORW_SEL_LEN-1:0] SEL_MEM = FORW_SEL_LEN'(1);
   localparam logic [FORW_SEL_LEN-1:0] SEL_WB  = FORW_SEL_LEN'(2);

   // EXE tag (p0), MEM tag (p1), WB tag (p2)
   logic                    vld_p0, wb_en_p0, mem_rd_p0;
   logic [REG_ADDR_LEN-1:0] dest_p0, src1_p0, src2_p0, st_src_p0;
   logic                    src2_used_p0, st_used_p0;
   logic                    vld_p1, wb_en_p1, mem_rd_p1;
   logic [REG_ADDR_LEN-1:0] dest_p1;
   logic                    vld_p2, wb_en_p2;
   logic [REG_ADDR_LEN-1:0] dest_p2;

   // A tag hits register r only if it is a live, writing instruction;
   // r0 is hard-wired zero and never creates a dependence.
   function automatic logic tag_hit(input logic                    vld,
                                    input logic                    wb_en,
                                    input logic [REG_ADDR_LEN-1:0] dest,
                                    input logic [REG_ADDR_LEN-1:0] r);
      return vld & wb_en & (dest == r) & (r != '0);
   endfunction

   // MEM is younger than WB, so it wins. A load still in MEM has no data
   // yet; the load-use stall guarantees the consumer meets it in WB instead.
   function automatic logic [FORW_SEL_LEN-1:0] fwd_sel(input logic used,
                                                       input logic mem_hit,
                                                       input logic mem_is_load,
                                                       input logic wb_hit);
      logic [FORW_SEL_LEN-1:0] sel;
      sel = SEL_OWN;
      if (used) begin
         if (mem_hit && !mem_is_load) sel = SEL_MEM;
         else if (wb_hit)             sel = SEL_WB;
      end
      return sel;
   endfunction

   logic fwd_active;
   logic exe_hit_id, mem_hit_id, raw_hazard, id_advance;

   // Selects: derived from the EXE tag, and only for a live EXE instruction
   // so a bubble never picks up a stale forward.
   assign fwd_active = forward_en & vld_p0;

   assign val1_sel = fwd_sel(fwd_active,
                             tag_hit(vld_p1, wb_en_p1, dest_p1, src1_p0), mem_rd_p1,
                             tag_hit(vld_p2, wb_en_p2, dest_p2, src1_p0));

   assign val2_sel = fwd_sel(fwd_active & src2_used_p0,
                             tag_hit(vld_p1, wb_en_p1, dest_p1, src2_p0), mem_rd_p1,
                             tag_hit(vld_p2, wb_en_p2, dest_p2, src2_p0));

   assign ST_val_sel = fwd_sel(fwd_active & st_used_p0,
                               tag_hit(vld_p1, wb_en_p1, dest_p1, st_src_p0), mem_rd_p1,
                               tag_hit(vld_p2, wb_en_p2, dest_p2, st_src_p0));

   // Stall: the ID instruction's used sources against the EXE and MEM tags.
   // WB needs no check; the register file writes before it is read.
   assign exe_hit_id = tag_hit(vld_p0, wb_en_p0, dest_p0, id_src1)
                     | (id_src2_used & tag_hit(vld_p0, wb_en_p0, dest_p0, id_src2))
                     | (id_st_used   & tag_hit(vld_p0, wb_en_p0, dest_p0, id_st_src));

   assign mem_hit_id = tag_hit(vld_p1, wb_en_p1, dest_p1, id_src1)
                     | (id_src2_used & tag_hit(vld_p1, wb_en_p1, dest_p1, id_src2))
                     | (id_st_used   & tag_hit(vld_p1, wb_en_p1, dest_p1, id_st_src));

   assign raw_hazard = forward_en ? (mem_rd_p0 & exe_hit_id)
                                  : (exe_hit_id | mem_hit_id);

   // A wrong-path instruction never stalls; it is dropped instead.
   assign stall      = id_valid & ~flush & raw_hazard;
   assign id_advance = id_valid & ~stall & ~flush;

   // ---- ID -> EXE boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         wb_en_p0  <= 1'b0;
         mem_rd_p0 <= 1'b0;
      end else begin
         vld_p0    <= id_advance;
         wb_en_p0  <= id_advance & id_wb_en;
         mem_rd_p0 <= id_advance & id_mem_read;
      end
   end

   always_ff @(posedge clk) begin
      if (id_advance) begin
         dest_p0      <= id_dest;
         src1_p0      <= id_src1;
         src2_p0      <= id_src2;
         st_src_p0    <= id_st_src;
         src2_used_p0 <= id_src2_used;
         st_used_p0   <= id_st_used;
      end
   end

   // ---- EXE -> MEM boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         wb_en_p1  <= 1'b0;
         mem_rd_p1 <= 1'b0;
      end else begin
         vld_p1    <= vld_p0;
         wb_en_p1  <= wb_en_p0;
         mem_rd_p1 <= mem_rd_p0;
      end
   end

   always_ff @(posedge clk) begin
      dest_p1 <= dest_p0;
   end

   // ---- MEM -> WB boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2   <= 1'b0;
         wb_en_p2 <= 1'b0;
      end else begin
         vld_p2   <= vld_p1;
         wb_en_p2 <= wb_en_p1;
      end
   end

   always_ff @(posedge clk) begin
      dest_p2 <= dest_p1;
   end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
module tb_forward_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, forward_en, flush, id_valid;
   logic [4:0] id_src1, id_src2, id_st_src, id_dest;
   logic       id_src2_used, id_st_used, id_wb_en, id_mem_read;
   logic [1:0] val1_sel, val2_sel, ST_val_sel;
   logic       stall;

   always #5 clk = ~clk;

   forward_hazard_ctrl #(.REG_ADDR_LEN(5), .FORW_SEL_LEN(2)) dut (
      .clk(clk), .rst(rst), .forward_en(forward_en), .flush(flush),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_st_src(id_st_src), .id_src2_used(id_src2_used), .id_st_used(id_st_used),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .val1_sel(val1_sel), .val2_sel(val2_sel), .ST_val_sel(ST_val_sel),
      .stall(stall)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       v;
      logic [4:0] s1, s2;
      logic       s2u;
      logic [4:0] st;
      logic       stu;
      logic [4:0] d;
      logic       wb, ld;
   } instr_t;

   typedef struct packed {
      logic       rst, fe, fl;
      instr_t     in;
      logic [1:0] e1, e2, est;
      logic       es;
   } vec_t;

   function automatic vec_t V(logic r, logic fe, logic fl, logic v,
                              logic [4:0] s1, logic [4:0] s2, logic s2u,
                              logic [4:0] st, logic stu, logic [4:0] d,
                              logic wb, logic ld,
                              logic [1:0] e1, logic [1:0] e2, logic [1:0] est, logic es);
      vec_t x;
      x.rst = r; x.fe = fe; x.fl = fl;
      x.in.v = v; x.in.s1 = s1; x.in.s2 = s2; x.in.s2u = s2u;
      x.in.st = st; x.in.stu = stu; x.in.d = d; x.in.wb = wb; x.in.ld = ld;
      x.e1 = e1; x.e2 = e2; x.est = est; x.es = es;
      return x;
   endfunction

   task automatic chk(input string nm, input int cyc, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic fe, input logic fl, input instr_t in);
      rst          = r;
      forward_en   = fe;
      flush        = fl;
      id_valid     = in.v;
      id_src1      = in.s1;
      id_src2      = in.s2;
      id_src2_used = in.s2u;
      id_st_src    = in.st;
      id_st_used   = in.stu;
      id_dest      = in.d;
      id_wb_en     = in.wb;
      id_mem_read  = in.ld;
   endtask

   // Reference model: the three in-flight instructions as whole records.
   instr_t mp [3];   // 0 = EXE, 1 = MEM, 2 = WB

   function automatic logic writes(instr_t p, logic [4:0] r);
      return p.v && p.wb && (p.d == r) && (r != 5'd0);
   endfunction

   function automatic logic [1:0] m_sel(logic fe, logic [4:0] r, logic used);
      if (!fe || !mp[0].v || !used) return 2'd0;
      if (writes(mp[1], r) && !mp[1].ld) return 2'd1;
      if (writes(mp[2], r)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic m_stall(logic fe, logic fl, instr_t id);
      logic [4:0] src [3];
      logic       use_ [3];
      logic       hz;
      if (!id.v || fl) return 1'b0;
      src[0] = id.s1; use_[0] = 1'b1;
      src[1] = id.s2; use_[1] = id.s2u;
      src[2] = id.st; use_[2] = id.stu;
      hz = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (use_[j]) begin
            if (fe) hz |= writes(mp[0], src[j]) && mp[0].ld;
            else    hz |= writes(mp[0], src[j]) || writes(mp[1], src[j]);
         end
      end
      return hz;
   endfunction

   task automatic m_step(input logic r, input logic fl, input logic st, input instr_t id);
      if (r) begin
         mp[0] = '0; mp[1] = '0; mp[2] = '0;
      end else begin
         mp[2] = mp[1];
         mp[1] = mp[0];
         mp[0] = (id.v && !st && !fl) ? id : '0;
      end
   endtask

   vec_t vecs [37];

   initial begin
      instr_t nop_i;
      nop_i = '0;

      //            rst fe fl v  s1 s2 2u st su d  wb ld  e1 e2 es stl
      vecs[0]  = V(0, 1, 0, 1, 1, 2, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0); // ADD r3 (after reset)
      vecs[1]  = V(0, 1, 0, 1, 3, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0); // SUB r4<-r3,r3
      vecs[2]  = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); // SUB in EXE
      vecs[3]  = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[4]  = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // ADD r5
      vecs[5]  = V(0, 1, 0, 1, 2, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // ADD r5
      vecs[6]  = V(0, 1, 0, 1, 5, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0); // OR r6<-r5
      vecs[7]  = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); // MEM wins
      vecs[8]  = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // ADD r5
      vecs[9]  = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0); // XOR r9
      vecs[10] = V(0, 1, 0, 1, 5, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0); // OR r6<-r5
      vecs[11] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); // from WB
      vecs[12] = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0); // LD r7
      vecs[13] = V(0, 1, 0, 1, 7, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 1); // ADD r8<-r7 stalls
      vecs[14] = V(0, 1, 0, 1, 7, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0); // held, released
      vecs[15] = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 7, 1, 1, 2, 0, 0, 0); // ADD gets WB; LD r7
      vecs[16] = V(0, 1, 0, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1); // ST r7 stalls
      vecs[17] = V(0, 1, 0, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0); // held, released
      vecs[18] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0); // ST value from WB
      vecs[19] = V(0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0); // fe=0 ADD r2
      vecs[20] = V(0, 0, 0, 1, 2, 2, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1); // SUB r9<-r2
      vecs[21] = V(0, 0, 0, 1, 2, 2, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1);
      vecs[22] = V(0, 0, 0, 1, 2, 2, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      vecs[23] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // SUB in EXE, sel 0
      vecs[24] = V(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // ADD r0
      vecs[25] = V(0, 0, 0, 1, 0, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0); // reads r0: no stall
      vecs[26] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[27] = V(0, 1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0); // LD r1
      vecs[28] = V(0, 1, 1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); // consumer + flush
      vecs[29] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // bubble in EXE
      vecs[30] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[31] = V(0, 1, 0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0); // ADD r4
      vecs[32] = V(0, 1, 0, 1, 2, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0); // ADD r4
      vecs[33] = V(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // reset, r4s in EXE/MEM
      vecs[34] = V(0, 0, 0, 1, 4, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0); // consumer of r4
      vecs[35] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // consumer in EXE
      vecs[36] = V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      drive(1'b1, 1'b1, 1'b0, nop_i);
      @(posedge clk);
      @(posedge clk);

      // Directed sequences
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].fe, vecs[i].fl, vecs[i].in);
         #1;
         chk("vec_val1_sel",   i, int'(val1_sel),   int'(vecs[i].e1));
         chk("vec_val2_sel",   i, int'(val2_sel),   int'(vecs[i].e2));
         chk("vec_ST_val_sel", i, int'(ST_val_sel), int'(vecs[i].est));
         chk("vec_stall",      i, int'(stall),      int'(vecs[i].es));
      end

      // Randomized run against the model, starting from a reset
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, nop_i);
      m_step(1'b1, 1'b0, 1'b0, nop_i);
      for (int c = 0; c < 4000; c++) begin
         instr_t ri;
         logic   r, fe, fl, es;
         @(negedge clk);
         r      = ($urandom_range(0, 99) == 0);
         fe     = ($urandom_range(0, 3) != 0);
         fl     = ($urandom_range(0, 7) == 0);
         ri.v   = ($urandom_range(0, 5) != 0);
         ri.s1  = 5'($urandom_range(0, 3));
         ri.s2  = 5'($urandom_range(0, 3));
         ri.s2u = $urandom_range(0, 1) == 1;
         ri.st  = 5'($urandom_range(0, 3));
         ri.stu = ($urandom_range(0, 3) == 0);
         ri.d   = 5'($urandom_range(0, 3));
         ri.wb  = ($urandom_range(0, 4) != 0);
         ri.ld  = ($urandom_range(0, 2) == 0);
         drive(r, fe, fl, ri);
         #1;
         es = m_stall(fe, fl, ri);
         chk("rnd_val1_sel",   c, int'(val1_sel),   int'(m_sel(fe, mp[0].s1, 1'b1)));
         chk("rnd_val2_sel",   c, int'(val2_sel),   int'(m_sel(fe, mp[0].s2, mp[0].s2u)));
         chk("rnd_ST_val_sel", c, int'(ST_val_sel), int'(m_sel(fe, mp[0].st, mp[0].stu)));
         chk("rnd_stall",      c, int'(stall),      int'(es));
         m_step(r, fl, es, ri);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
